bht_ctrl: RTL and testbench
===========================

Name: bht_ctrl

Overview:
- Controller for a branch history table (BHT) of 2-bit saturating predictor counters, indexed by PC.
- Sits between IF and EX.
  - IF issues prediction lookups.
  - EX reports resolved branch outcomes, which are buffered in an update FIFO and written back one per cycle.
- After reset, a sequencer initialises every table entry before lookups are served.

Parameters:
- IDX_BITS, 4: table index width; table has 2**IDX_BITS entries.
- PC_W, 32: program counter width.
- Q_DEPTH, 4: update FIFO depth; power of 2, ≥ 2.
- INIT_ST, 2'b10: counter value written to every entry during init (WT).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- lkp_valid  in  1  IF lookup request.
- lkp_pc  in  PC_W  PC of the fetched instruction.
- lkp_ready  out  1  controller accepts lookups; low during INIT.
- pred_valid  out  1  prediction result valid, one cycle after an accepted lookup.
- pred_taken  out  1  predicted direction (counter bit 1).
- pred_state  out  2  raw counter value of the looked-up entry.
- upd_valid  in  1  EX resolved-branch update.
- upd_pc  in  PC_W  PC of the resolved branch.
- upd_taken  in  1  actual outcome (1 = taken).
- upd_ready  out  1  FIFO not full.
- init_busy  out  1  high while in INIT.
- upd_drop_cnt  out  8  count of cycles with upd_valid=1 and upd_ready=0; saturates at 255.

Behaviour:
- Reset: synchronous, active-high; when reset=1 at a rising clk edge:
  - FSM → INIT, init pointer = 0, FIFO emptied, upd_drop_cnt = 0.
  - Outputs: pred_valid=0, pred_taken=0, pred_state=2'b00, lkp_ready=0, init_busy=1, upd_ready=1.
  - Table contents are not reset directly; INIT rewrites them.
  - Reset mid-operation (any state, any FIFO occupancy) discards all pending updates and restarts INIT from index 0.
- Index mapping: idx = pc[IDX_BITS+1:2]; pc[1:0] ignored.
- Counter encoding: SNT=00, WNT=01, WT=10, ST=11.
  - Taken: +1, saturating at 11.
  - Not taken: −1, saturating at 00.
  - pred_taken = counter[1].
- FSM INIT:
  - Each cycle writes INIT_ST to table[ptr] and increments ptr.
  - After writing entry 2**IDX_BITS−1, go to RUN. INIT therefore lasts exactly 2**IDX_BITS cycles after reset deasserts.
  - init_busy=1, lkp_ready=0.
  - Lookups are ignored (pred_valid stays 0).
  - FIFO accepts pushes but does not drain.
- FSM RUN:
  - init_busy=0, lkp_ready=1.
  - RUN has no exit except reset.
- Lookup:
  - Accepted when lkp_valid & lkp_ready.
  - Result is registered: pred_valid=1 on the following cycle with pred_state/pred_taken of the indexed entry.
  - With no accepted lookup, pred_valid=0 next cycle; pred_state/pred_taken hold their last value.
- Update FIFO:
  - Push when upd_valid & upd_ready; entry = {idx, taken}.
  - upd_ready = (count != Q_DEPTH), computed from registered count only. No push is accepted while full, even if a pop occurs that cycle.
  - In RUN with FIFO non-empty: pop the head, read-modify-write table[head.idx] in the same cycle.
  - An entry pushed into an empty FIFO drains no earlier than the next cycle.
  - Simultaneous push and pop leaves count unchanged.
  - Read/write pointers wrap modulo Q_DEPTH.
- Lookup/write collision: if a lookup and a drain write hit the same index in the same cycle, the prediction returns the post-update counter value (write-first bypass).
  - Updates still waiting in the FIFO are not forwarded.
- upd_drop_cnt increments on every cycle with upd_valid=1 and upd_ready=0, and saturates at 255.

Test Plan:
- Reset, then wait: init_busy high exactly 16 cycles (IDX_BITS=4). Afterwards, a lookup of every PC 0x00..0x3C returns pred_valid=1, pred_state=2'b10, pred_taken=1 one cycle later.
- Saturation: three taken updates for pc 0x10, then lookup → pred_state=11. Then four not-taken updates → pred_state=00, pred_taken=0. A further not-taken update keeps 00.
- FIFO full: hold upd_valid=1 for 8 cycles during INIT → upd_ready falls after 4 pushes, upd_drop_cnt=4. On RUN entry, entries drain one per cycle and upd_ready rises the cycle after the first pop.
- Collision: entry 5 = 10; a drain of a taken update for pc 0x14 coincides with a lookup of pc 0x14 → next-cycle pred_state=11.
- Aliasing: an update at pc 0x44 (idx 1) changes the lookup result for pc 0x04.
- Reset mid-RUN with 3 FIFO entries pending → FIFO empty, init_busy=1 for 16 cycles, all entries read back 10, upd_drop_cnt=0.

Source files
------------

// File: rtl/bht_ctrl.sv
// bht_ctrl -- branch history table controller.
//
// Holds 2**IDX_BITS two-bit saturating predictor counters indexed by
// pc[IDX_BITS+1:2]. After reset a sequencer writes INIT_ST into every
// entry (INIT). Then lookups are served (RUN). Resolved branches are
// buffered in an update FIFO and written back one per cycle while in RUN.
//
// Ports:
//   clk, reset      clock and synchronous active-high reset
//   lkp_valid/pc    IF lookup request; lkp_ready is high only in RUN
//   pred_valid      registered prediction, one cycle after an accepted lookup
//   pred_taken      counter bit 1 of the looked-up entry
//   pred_state      raw two-bit counter of the looked-up entry
//   upd_valid/pc/taken  EX resolved-branch update; upd_ready = FIFO not full
//   init_busy       high while the table is being initialised
//   upd_drop_cnt    saturating count of cycles with a refused update
module bht_ctrl #(
  parameter int         IDX_BITS = 4,
  parameter int         PC_W     = 32,
  parameter int         Q_DEPTH  = 4,
  parameter logic [1:0] INIT_ST  = 2'b10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            lkp_valid,
  input  logic [PC_W-1:0] lkp_pc,
  output logic            lkp_ready,
  output logic            pred_valid,
  output logic            pred_taken,
  output logic [1:0]      pred_state,
  input  logic            upd_valid,
  input  logic [PC_W-1:0] upd_pc,
  input  logic            upd_taken,
  output logic            upd_ready,
  output logic            init_busy,
  output logic [7:0]      upd_drop_cnt
);

  localparam int ENTRIES = 1 << IDX_BITS;
  localparam int AW      = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1;
  localparam int CW      = AW + 1;
  localparam logic [CW-1:0]       FULL     = CW'(Q_DEPTH);
  localparam logic [IDX_BITS-1:0] LAST_IDX = {IDX_BITS{1'b1}};

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t state, state_nxt;

  logic [IDX_BITS-1:0] init_ptr;
  logic [1:0]          bht [ENTRIES];
  logic [IDX_BITS:0]   fifo_mem [Q_DEPTH];
  logic [AW-1:0]       rd_ptr, wr_ptr;
  logic [CW-1:0]       count;

  logic [IDX_BITS-1:0] lkp_idx_p0, upd_idx_p0, head_idx_p0;
  logic                head_taken_p0;
  logic [1:0]          head_new_p0, lkp_val_p0;
  logic                push, pop, lkp_fire;
  logic                unused_pc_bits;

  function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
    else       return (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Only the word-aligned index bits of a PC select an entry.
  assign lkp_idx_p0     = lkp_pc[IDX_BITS+1:2];
  assign upd_idx_p0     = upd_pc[IDX_BITS+1:2];
  assign unused_pc_bits = ^{lkp_pc[PC_W-1:IDX_BITS+2], lkp_pc[1:0],
                            upd_pc[PC_W-1:IDX_BITS+2], upd_pc[1:0]};

  // Fullness comes from the registered count only, so a pop in the same
  // cycle never frees a slot for a push.
  assign upd_ready = (count != FULL);
  assign push      = upd_valid & upd_ready;
  assign pop       = (state == S_RUN) && (count != '0);
  assign lkp_fire  = lkp_valid & lkp_ready;

  assign {head_idx_p0, head_taken_p0} = fifo_mem[rd_ptr];
  assign head_new_p0 = sat_update(bht[head_idx_p0], head_taken_p0);

  // Write-first bypass: a lookup colliding with this cycle's drain write
  // sees the updated counter. Entries still queued are not forwarded.
  assign lkp_val_p0 = (pop && (head_idx_p0 == lkp_idx_p0)) ? head_new_p0
                                                           : bht[lkp_idx_p0];

  always_comb begin
    state_nxt = state;
    init_busy = 1'b0;
    lkp_ready = 1'b0;
    case (state)
      S_INIT: begin
        init_busy = 1'b1;
        if (init_ptr == LAST_IDX) state_nxt = S_RUN;
      end
      S_RUN:   lkp_ready = 1'b1;
      default: state_nxt = S_INIT;
    endcase
  end

  // ---- stage p0 -> p1: control state and registered prediction ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_INIT;
      init_ptr     <= '0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      pred_valid   <= 1'b0;
      pred_state   <= 2'b00;
      upd_drop_cnt <= 8'd0;
    end else begin
      state      <= state_nxt;
      pred_valid <= lkp_fire;
      if (state == S_INIT) init_ptr <= init_ptr + IDX_BITS'(1);
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (lkp_fire) pred_state <= lkp_val_p0;
      if (upd_valid && !upd_ready) upd_drop_cnt <= sat_inc8(upd_drop_cnt);
    end
  end

  // ---- stage p0 -> p1: table and FIFO storage ----
  always_ff @(posedge clk) begin
    if (state == S_INIT)  bht[init_ptr]    <= INIT_ST;
    else if (pop)         bht[head_idx_p0] <= head_new_p0;
    if (push) fifo_mem[wr_ptr] <= {upd_idx_p0, upd_taken};
  end

  assign pred_taken = pred_state[1];

endmodule

// File: tb/tb_bht_ctrl.sv
module tb_bht_ctrl;
  localparam int PC_W = 32;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            lkp_valid = 1'b0;
  logic [PC_W-1:0] lkp_pc = '0;
  logic            lkp_ready;
  logic            pred_valid;
  logic            pred_taken;
  logic [1:0]      pred_state;
  logic            upd_valid = 1'b0;
  logic [PC_W-1:0] upd_pc = '0;
  logic            upd_taken = 1'b0;
  logic            upd_ready;
  logic            init_busy;
  logic [7:0]      upd_drop_cnt;

  int vectors = 0;
  int miscompares = 0;
  logic [1:0] exp_q[$];
  logic [1:0] mon_exp;

  bht_ctrl #(.IDX_BITS(4), .PC_W(PC_W), .Q_DEPTH(4), .INIT_ST(2'b10)) dut (
    .clk(clk), .reset(reset),
    .lkp_valid(lkp_valid), .lkp_pc(lkp_pc), .lkp_ready(lkp_ready),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_state(pred_state),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_ready(upd_ready), .init_busy(init_busy), .upd_drop_cnt(upd_drop_cnt)
  );

  always #5 clk = ~clk;

  // Scoreboard consumer: every prediction must match the oldest expectation.
  always @(negedge clk) begin
    if (pred_valid === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL pred_unexpected: pred_valid=1 state=%b, required no prediction", pred_state);
      end else begin
        mon_exp = exp_q.pop_front();
        if (pred_state !== mon_exp || pred_taken !== mon_exp[1]) begin
          miscompares++;
          $display("FAIL pred_value: state=%b taken=%b, required state=%b taken=%b",
                   pred_state, pred_taken, mon_exp, mon_exp[1]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic lookup(input logic [PC_W-1:0] pc, input logic [1:0] exp);
    lkp_valid = 1'b1;
    lkp_pc    = pc;
    exp_q.push_back(exp);
    tick();
    lkp_valid = 1'b0;
  endtask

  task automatic update(input logic [PC_W-1:0] pc, input logic taken);
    upd_valid = 1'b1;
    upd_pc    = pc;
    upd_taken = taken;
    tick();
    upd_valid = 1'b0;
  endtask

  task automatic drain_preds(input string name);
    int k = 0;
    while (exp_q.size() != 0 && k < 8) begin
      tick();
      k++;
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s_missing: %0d predictions outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_init(input int start, output int n);
    n = start;
    while (init_busy === 1'b1 && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    int n;
    do_reset();
    vectors++;
    if ({init_busy, lkp_ready, pred_valid, pred_taken, pred_state, upd_ready, upd_drop_cnt}
        !== {1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 8'd0}) begin
      miscompares++;
      $display("FAIL reset_outputs: busy=%b lrdy=%b pv=%b pt=%b ps=%b urdy=%b drop=%0d, required 1 0 0 0 00 1 0",
               init_busy, lkp_ready, pred_valid, pred_taken, pred_state, upd_ready, upd_drop_cnt);
    end
    // Lookups offered throughout INIT must be ignored.
    lkp_valid = 1'b1;
    lkp_pc    = 32'h0;
    n = 0;
    while (init_busy === 1'b1 && n < 40) begin
      tick();
      n++;
      vectors++;
      if (pred_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL init_lookup_ignored: pred_valid=%b, required 0", pred_valid);
      end
    end
    lkp_valid = 1'b0;
    vectors++;
    if (n != 16) begin
      miscompares++;
      $display("FAIL init_length: %0d cycles, required 16", n);
    end
    vectors++;
    if (lkp_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL run_lkp_ready: %b, required 1", lkp_ready);
    end
  endtask

  task automatic test_init_values();
    for (int i = 0; i < 16; i++) lookup(32'(i * 4), 2'b10);
    drain_preds("init_values");
    idle(1);
    vectors++;
    if (pred_valid !== 1'b0 || pred_state !== 2'b10) begin
      miscompares++;
      $display("FAIL pred_hold: pv=%b ps=%b, required pv=0 ps=10", pred_valid, pred_state);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 3; i++) update(32'h10, 1'b1);
    idle(2);
    lookup(32'h10, 2'b11);
    for (int i = 0; i < 4; i++) update(32'h10, 1'b0);
    idle(2);
    lookup(32'h10, 2'b00);
    update(32'h10, 1'b0);
    idle(2);
    lookup(32'h10, 2'b00);
    drain_preds("saturation");
  endtask

  task automatic test_collision();
    // Update is pushed, then drains exactly when the lookup is sampled.
    update(32'h14, 1'b1);
    lookup(32'h14, 2'b11);
    idle(2);
    lookup(32'h14, 2'b11);
    drain_preds("collision");
  endtask

  task automatic test_aliasing();
    lookup(32'h04, 2'b10);
    update(32'h44, 1'b0);
    idle(2);
    lookup(32'h04, 2'b01);
    drain_preds("aliasing");
  endtask

  task automatic test_back_to_back();
    update(32'h18, 1'b1);
    update(32'h1C, 1'b0);
    update(32'h18, 1'b1);
    update(32'h3D, 1'b1);
    idle(3);
    lookup(32'h18, 2'b11);
    lookup(32'h1E, 2'b01);
    lookup(32'h3C, 2'b11);
    lookup(32'h00, 2'b10);
    drain_preds("back_to_back");
  endtask

  task automatic test_fifo_full();
    int n;
    do_reset();
    upd_valid = 1'b1;
    upd_pc    = 32'h20;
    upd_taken = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      vectors++;
      if (upd_ready !== (i < 4)) begin
        miscompares++;
        $display("FAIL fifo_full_ready_c%0d: upd_ready=%b, required %b", i, upd_ready, (i < 4));
      end
    end
    upd_valid = 1'b0;
    vectors++;
    if (upd_drop_cnt !== 8'd4) begin
      miscompares++;
      $display("FAIL fifo_full_drops: %0d, required 4", upd_drop_cnt);
    end
    wait_init(8, n);
    vectors++;
    if (n != 16) begin
      miscompares++;
      $display("FAIL fifo_full_init_length: %0d cycles, required 16", n);
    end
    vectors++;
    if (upd_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL fifo_full_run_entry: upd_ready=%b, required 0", upd_ready);
    end
    tick();
    vectors++;
    if (upd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL fifo_first_pop_ready: upd_ready=%b, required 1", upd_ready);
    end
    idle(4);
    lookup(32'h20, 2'b11);
    lookup(32'h24, 2'b10);
    drain_preds("fifo_full");
  endtask

  task automatic test_reset_mid_run();
    int n;
    do_reset();
    upd_valid = 1'b1;
    upd_pc    = 32'h08;
    upd_taken = 1'b1;
    idle(6);
    upd_valid = 1'b0;
    vectors++;
    if (upd_drop_cnt !== 8'd2) begin
      miscompares++;
      $display("FAIL midrun_pre_drops: %0d, required 2", upd_drop_cnt);
    end
    wait_init(6, n);
    tick();  // one pop; three updates remain queued
    lookup(32'h08, 2'b10);  // sampled alongside the second drain of idx 2 (10 -> 11 -> 11)
    exp_q.delete();
    exp_q.push_back(2'b11);
    reset = 1'b1;
    tick();
    exp_q.delete();
    reset = 1'b0;
    vectors++;
    if ({upd_ready, init_busy, lkp_ready, pred_valid, pred_state, upd_drop_cnt}
        !== {1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 8'd0}) begin
      miscompares++;
      $display("FAIL midrun_reset_outputs: urdy=%b busy=%b lrdy=%b pv=%b ps=%b drop=%0d, required 1 1 0 0 00 0",
               upd_ready, init_busy, lkp_ready, pred_valid, pred_state, upd_drop_cnt);
    end
    wait_init(0, n);
    vectors++;
    if (n != 16) begin
      miscompares++;
      $display("FAIL midrun_init_length: %0d cycles, required 16", n);
    end
    idle(6);
    for (int i = 0; i < 16; i++) lookup(32'(i * 4), 2'b10);
    drain_preds("midrun_readback");
  endtask

  initial begin
    test_reset();
    test_init_values();
    test_saturation();
    test_collision();
    test_aliasing();
    test_back_to_back();
    test_fifo_full();
    test_reset_mid_run();
    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
